// File: rtl/user_fifo_sbr_pkg.sv
// Shared types and constants for the user-domain OBI mailbox FIFO.
// Holds the OBI structs, register offsets, STATUS bit positions and the user address map entry.
package user_fifo_sbr_pkg;

   localparam int unsigned IdWidth   = 4;
   localparam int unsigned DataWidth = 32;

   typedef struct packed {
      logic [31:0]          addr;
      logic                 we;
      logic [3:0]           be;
      logic [DataWidth-1:0] wdata;
      logic [IdWidth-1:0]   aid;
   } obi_a_chan_t;

   typedef struct packed {
      logic        req;
      obi_a_chan_t a;
   } obi_req_t;

   typedef struct packed {
      logic [DataWidth-1:0] rdata;
      logic [IdWidth-1:0]   rid;
      logic                 err;
   } obi_r_chan_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      obi_r_chan_t r;
   } obi_rsp_t;

   typedef obi_req_t sbr_obi_req_t;
   typedef obi_rsp_t sbr_obi_rsp_t;

   localparam logic [31:0] FifoDataOffset   = 32'h0;
   localparam logic [31:0] FifoStatusOffset = 32'h4;
   localparam logic [31:0] FifoIrqCfgOffset = 32'h8;
   localparam logic [31:0] FifoCtrlOffset   = 32'hC;

   localparam int unsigned StatusEmptyBit = 8;
   localparam int unsigned StatusFullBit  = 9;
   localparam int unsigned StatusOvfBit   = 10;
   localparam int unsigned StatusUdfBit   = 11;
   localparam int unsigned IrqCfgEnBit    = 8;

   typedef struct packed {
      logic [31:0] idx;
      logic [31:0] start_addr;
      logic [31:0] end_addr;
   } addr_rule_t;

   localparam int unsigned UserError   = 0;
   localparam int unsigned UserFifo    = 1;
   localparam int unsigned NumDemuxSbr = 2;

   localparam addr_rule_t [NumDemuxSbr-1:0] user_addr_map = '{
      '{idx: UserFifo,  start_addr: 32'h2000_1000, end_addr: 32'h2000_1010},
      '{idx: UserError, start_addr: 32'h2000_0000, end_addr: 32'h2000_1000}
   };

endpackage

// File: rtl/user_fifo_sbr_if.sv
// OBI request/response bundle between the user demux and the mailbox FIFO.
interface user_fifo_sbr_if;
   import user_fifo_sbr_pkg::*;

   obi_req_t req;
   obi_rsp_t rsp;

   modport master (output req, input rsp);
   modport slave  (input req, output rsp);
endinterface

// File: rtl/user_fifo_sbr_core.sv
// Circular-buffer storage for the mailbox: pointers, occupancy count and head word.
module user_fifo_core #(
   parameter int unsigned Depth = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [31:0]              wdata_i,
   output logic [$clog2(Depth):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [31:0]              head_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic [31:0]     mem_q [Depth];
   logic            do_push, do_pop;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   // Flush only rewinds the bookkeeping; the stale words stay in storage.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/user_fifo_sbr.sv
// OBI subordinate mailbox: register decode, one-cycle response, sticky error flags and level irq.
module user_fifo_sbr
   import user_fifo_sbr_pkg::*;
#(
   parameter int unsigned Depth = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   user_fifo_sbr_if.slave   obi,
   output logic             irq_o
);

   localparam int unsigned CntW = $clog2(Depth) + 1;

   localparam logic [1:0] SelData   = FifoDataOffset[3:2];
   localparam logic [1:0] SelStatus = FifoStatusOffset[3:2];
   localparam logic [1:0] SelIrqCfg = FifoIrqCfgOffset[3:2];
   localparam logic [1:0] SelCtrl   = FifoCtrlOffset[3:2];

   obi_a_chan_t        a;
   logic               req;
   logic [CntW-1:0]    count;
   logic [7:0]         count_ext;
   logic               full, empty;
   logic [31:0]        head;
   logic [31:0]        status_word;

   logic               push, pop, flush;
   logic [31:0]        rdata_d, rdata_q;
   logic               err_d, err_q;
   logic               rvalid_q;
   logic [IdWidth-1:0] rid_q;
   logic               ovf_d, ovf_q, udf_d, udf_q;
   logic [7:0]         thr_d, thr_q;
   logic               en_d, en_q;
   logic               irq_d, irq_q;
   logic               unused_bits;

   assign a   = obi.req.a;
   assign req = obi.req.req;

   assign unused_bits = ^{a.addr[31:4], a.addr[1:0], a.be[3:2], a.wdata[31:9]};

   user_fifo_core #(.Depth(Depth)) u_core (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .wdata_i (a.wdata),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty),
      .head_o  (head)
   );

   assign count_ext = {{(8-CntW){1'b0}}, count};

   always_comb begin
      status_word                 = '0;
      status_word[7:0]            = count_ext;
      status_word[StatusEmptyBit] = empty;
      status_word[StatusFullBit]  = full;
      status_word[StatusOvfBit]   = ovf_q;
      status_word[StatusUdfBit]   = udf_q;
   end

   always_comb begin
      push    = 1'b0;
      pop     = 1'b0;
      flush   = 1'b0;
      rdata_d = '0;
      err_d   = 1'b0;
      ovf_d   = ovf_q;
      udf_d   = udf_q;
      thr_d   = thr_q;
      en_d    = en_q;
      if (req) begin
         case (a.addr[3:2])
            SelData: begin
               if (a.we) begin
                  if (full) begin
                     ovf_d = 1'b1;
                     err_d = 1'b1;
                  end else begin
                     push = 1'b1;
                  end
               end else if (empty) begin
                  udf_d = 1'b1;
                  err_d = 1'b1;
               end else begin
                  pop     = 1'b1;
                  rdata_d = head;
               end
            end
            SelStatus: begin
               if (!a.we) rdata_d = status_word;
            end
            SelIrqCfg: begin
               if (a.we) begin
                  if (a.be[0]) thr_d = a.wdata[7:0];
                  if (a.be[1]) en_d  = a.wdata[IrqCfgEnBit];
               end else begin
                  rdata_d[7:0]        = thr_q;
                  rdata_d[IrqCfgEnBit] = en_q;
               end
            end
            SelCtrl: begin
               if (a.we && a.be[0]) begin
                  flush = a.wdata[0];
                  if (a.wdata[1]) begin
                     ovf_d = 1'b0;
                     udf_d = 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Threshold above Depth can never be reached since count saturates at Depth.
   assign irq_d = en_q && (count_ext >= thr_q) && !empty;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rid_q    <= '0;
         err_q    <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         thr_q    <= '0;
         en_q     <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         rvalid_q <= req;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         if (req) rid_q <= a.aid;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         thr_q    <= thr_d;
         en_q     <= en_d;
         irq_q    <= irq_d;
      end
   end

   always_comb begin
      obi.rsp         = '0;
      obi.rsp.gnt     = req;
      obi.rsp.rvalid  = rvalid_q;
      obi.rsp.r.rdata = rdata_q;
      obi.rsp.r.rid   = rid_q;
      obi.rsp.r.err   = err_q;
   end

   assign irq_o = irq_q;

endmodule
